// File: rtl/riscv_aes_result_reader.sv
// Purpose: captures the 128-bit AES engine result and serves it to the core one 32-bit word at a time.
// Latency: read data and status appear 1 cycle after ren_i; a capture makes ready_o visible 1 cycle after aes_done_i.
// Backpressure: none; reads are accepted every cycle, and the buffer is released once every word has been read.
module riscv_aes_result_reader #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    test_en_i,
  input  logic                                    aes_start_i,
  input  logic                                    aes_done_i,
  input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]   aes_result_i,
  input  logic                                    clear_i,
  input  logic                                    ren_i,
  input  logic [ADDR_WIDTH-1:0]                   raddr_i,
  output logic [DATA_WIDTH-1:0]                   rdata_o,
  output logic                                    rvalid_o,
  output logic                                    rerr_o,
  output logic                                    busy_o,
  output logic                                    ready_o,
  output logic                                    overrun_o
);

  localparam int NUM_WORDS = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [NUM_WORDS*DATA_WIDTH-1:0]   buf_q;
  logic [NUM_WORDS-1:0]              mask_q;
  logic [NUM_WORDS-1:0]              mask_set;
  logic [DATA_WIDTH-1:0]             rd_word;
  logic                              rd_ok;

  // A read only returns buffer contents while a result is held and test mode is off.
  assign rd_ok = ren_i && (state_q == READY) && !test_en_i;

  // Read-mask as it would look after this cycle's accepted read.
  always_comb begin
    mask_set = mask_q;
    if (rd_ok) begin
      mask_set[raddr_i] = 1'b1;
    end
  end

  // Select the addressed word out of the buffer.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (raddr_i == k[ADDR_WIDTH-1:0]) begin
        rd_word = buf_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: test mode, then clear, then normal transitions.
  always_comb begin
    state_d = state_q;
    if (test_en_i || clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (aes_start_i) state_d = BUSY;
        BUSY:    if (aes_done_i)  state_d = READY;
        READY: begin
          // A new launch wins over releasing the buffer.
          if (aes_start_i)      state_d = BUSY;
          else if (&mask_set)   state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy_o  = (state_q == BUSY);
    ready_o = (state_q == READY);
  end

  // Result buffer: loaded only on completion while BUSY; kept across clear and new launches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (test_en_i) begin
      buf_q <= '1;
    end else if (!clear_i && (state_q == BUSY) && aes_done_i) begin
      buf_q <= aes_result_i;
    end
  end

  // Read mask: tracks which words of the held result the core has consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (test_en_i || clear_i) begin
      mask_q <= '0;
    end else begin
      case (state_q)
        BUSY:    if (aes_done_i) mask_q <= '0;
        READY: begin
          if (aes_start_i || (&mask_set)) mask_q <= '0;
          else                            mask_q <= mask_set;
        end
        default: mask_q <= mask_q;
      endcase
    end
  end

  // Sticky overrun: a completion that nobody was waiting for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_o <= 1'b0;
    end else if (test_en_i || clear_i) begin
      overrun_o <= 1'b0;
    end else if (aes_done_i && (state_q != BUSY)) begin
      overrun_o <= 1'b1;
    end
  end

  // Registered read port: every request completes next cycle, with error when no result is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_o <= 1'b0;
      rerr_o   <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= ren_i;
      rerr_o   <= ren_i && !rd_ok;
      if (ren_i) begin
        rdata_o <= rd_ok ? rd_word : '0;
      end
    end
  end

endmodule
